// File: rtl/pmod_adc_pkg.sv
// Shared state encoding, default parameter values and counter helpers for the
// PMOD ADC capture block.
package pmod_adc_pkg;

    localparam int unsigned DefNumCh       = 1;
    localparam int unsigned DefFrameBits   = 16;
    localparam int unsigned DefDataBits    = 12;
    localparam int unsigned DefQuietCycles = 1;

    // Wide enough for FRAME_BITS-1 (max 31) and QUIET_CYCLES-1 (max 14).
    localparam int unsigned CntW = 5;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StConv  = 3'd1,
        StQuiet = 3'd2,
        StHold  = 3'd3
    } state_e;

    function automatic logic [CntW-1:0] cnt_load(input int unsigned n);
        return CntW'(n - 1);
    endfunction

endpackage

// File: rtl/pmod_adc_capture_if.sv
// Control, serial data and result handshake bundle of the PMOD ADC capture block.
interface pmod_adc_capture_if
    import pmod_adc_pkg::*;
#(
    parameter int unsigned NUM_CH    = DefNumCh,
    parameter int unsigned DATA_BITS = DefDataBits
) ();

    logic                          start;
    logic                          mic_en;
    logic                          cont;
    logic [NUM_CH-1:0]             sdata;
    logic                          sample_ready;
    logic                          clr_overrun;
    logic                          ncs;
    logic                          done;
    logic [NUM_CH*DATA_BITS-1:0]   sample;
    logic                          sample_valid;
    logic                          overrun;

    modport master (
        output start, mic_en, cont, sdata, sample_ready, clr_overrun,
        input  ncs, done, sample, sample_valid, overrun
    );

    modport slave (
        input  start, mic_en, cont, sdata, sample_ready, clr_overrun,
        output ncs, done, sample, sample_valid, overrun
    );

endinterface

// File: rtl/pmod_adc_shreg.sv
// Per-channel serial-in shift register; dout_o presents the low DATA_BITS of the
// word as it will be after the current shift, so the final frame bit is included.
module pmod_adc_shreg #(
    parameter int unsigned FRAME_BITS = 16,
    parameter int unsigned DATA_BITS  = 12
) (
    input  logic                 clk_sclk,
    input  logic                 rst,
    input  logic                 en_i,
    input  logic                 din_i,
    output logic [DATA_BITS-1:0] dout_o
);

    logic [FRAME_BITS-1:0] shreg_q;
    logic [FRAME_BITS-1:0] shreg_d;
    logic                  unused_msb;

    assign shreg_d = {shreg_q[FRAME_BITS-2:0], din_i};

    always_ff @(negedge clk_sclk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
        end else if (en_i) begin
            shreg_q <= shreg_d;
        end
    end

    assign dout_o     = shreg_d[DATA_BITS-1:0];
    // The oldest bit falls off the top and is never part of a result.
    assign unused_msb = shreg_q[FRAME_BITS-1];

endmodule

// File: rtl/pmod_adc_capture.sv
// Frame sequencer for one or more SPI-style ADCs sharing ncs/clk_sclk; captures
// one result per channel per frame with a valid/overrun handshake.
module pmod_adc_capture
    import pmod_adc_pkg::*;
#(
    parameter int unsigned NUM_CH       = DefNumCh,
    parameter int unsigned FRAME_BITS   = DefFrameBits,
    parameter int unsigned DATA_BITS    = DefDataBits,
    parameter int unsigned QUIET_CYCLES = DefQuietCycles
) (
    input  logic               clk_sclk,
    input  logic               rst,
    pmod_adc_capture_if.slave  bus
);

    state_e                      state_q;
    logic [CntW-1:0]             cnt_q;
    logic [NUM_CH*DATA_BITS-1:0] sample_q;
    logic                        valid_q;
    logic                        overrun_q;

    logic                        shift_en;
    logic                        frame_end;
    logic [NUM_CH*DATA_BITS-1:0] frame_data;

    assign shift_en  = (state_q == StConv);
    assign frame_end = shift_en && (cnt_q == '0);

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        pmod_adc_shreg #(
            .FRAME_BITS (FRAME_BITS),
            .DATA_BITS  (DATA_BITS)
        ) u_shreg (
            .clk_sclk (clk_sclk),
            .rst      (rst),
            .en_i     (shift_en),
            .din_i    (bus.sdata[k]),
            .dout_o   (frame_data[k*DATA_BITS +: DATA_BITS])
        );
    end

    always_ff @(negedge clk_sclk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start && bus.mic_en) begin
                        state_q <= StConv;
                        cnt_q   <= cnt_load(FRAME_BITS);
                    end
                end
                StConv: begin
                    // start/mic_en are ignored here so a frame always completes.
                    if (cnt_q == '0) begin
                        state_q <= StQuiet;
                        cnt_q   <= cnt_load(QUIET_CYCLES);
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StQuiet: begin
                    if (cnt_q == '0) begin
                        if (bus.cont && bus.start && bus.mic_en) begin
                            state_q <= StConv;
                            cnt_q   <= cnt_load(FRAME_BITS);
                        end else if (bus.start) begin
                            state_q <= StHold;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                StHold: begin
                    if (!bus.start) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                end
            endcase

            if (frame_end) begin
                sample_q <= frame_data;
            end

            // A load consumed on the same edge it happens is not an overrun.
            if (frame_end) begin
                valid_q <= 1'b1;
            end else if (bus.sample_ready) begin
                valid_q <= 1'b0;
            end

            if (frame_end && valid_q && !bus.sample_ready) begin
                overrun_q <= 1'b1;
            end else if (bus.clr_overrun) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign bus.ncs          = (state_q != StConv);
    assign bus.done         = (state_q == StIdle);
    assign bus.sample       = sample_q;
    assign bus.sample_valid = valid_q;
    assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_pmod_adc_capture.sv
// Self-checking bench for pmod_adc_capture: a 2-channel 16/12-bit instance plus a
// 1-channel 4/4-bit smoke instance, with a queue scoreboard of expected samples.
module tb_pmod_adc_capture;

    logic clk_sclk = 1'b1;
    logic rst      = 1'b0;

    always #5 clk_sclk = ~clk_sclk;

    pmod_adc_capture_if #(.NUM_CH(2), .DATA_BITS(12)) bus ();
    pmod_adc_capture_if #(.NUM_CH(1), .DATA_BITS(4))  bus_s ();

    pmod_adc_capture #(
        .NUM_CH       (2),
        .FRAME_BITS   (16),
        .DATA_BITS    (12),
        .QUIET_CYCLES (2)
    ) u_dut (
        .clk_sclk (clk_sclk),
        .rst      (rst),
        .bus      (bus)
    );

    pmod_adc_capture #(
        .NUM_CH       (1),
        .FRAME_BITS   (4),
        .DATA_BITS    (4),
        .QUIET_CYCLES (1)
    ) u_dut_s (
        .clk_sclk (clk_sclk),
        .rst      (rst),
        .bus      (bus_s)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] stream_q[$];
    logic [23:0] exp_q[$];
    logic [3:0]  exp_s_q[$];
    logic [31:0] cur_word = '0;
    int          bit_pos  = -1;

    // ADC model: presents the next MSB-first bit half a cycle before each falling edge.
    always @(posedge clk_sclk) begin
        if (bus.ncs === 1'b0) begin
            if (bit_pos < 0) begin
                if (stream_q.size() > 0) cur_word = stream_q.pop_front();
                else cur_word = '0;
                bit_pos = 15;
            end
            bus.sdata[0] = cur_word[bit_pos];
            bus.sdata[1] = cur_word[16 + bit_pos];
            bit_pos--;
        end
    end

    logic prev_ncs = 1'b1;
    int   low_cnt = 0, high_cnt = 0, last_low = 0, last_gap = 0, frames = 0;

    always @(negedge clk_sclk) begin
        #1;
        if (bus.ncs === 1'b0) begin
            if (prev_ncs) begin
                last_gap = high_cnt;
                low_cnt  = 0;
            end
            low_cnt++;
        end else begin
            if (!prev_ncs) begin
                last_low = low_cnt;
                frames++;
                high_cnt = 0;
            end
            high_cnt++;
        end
        prev_ncs = (bus.ncs !== 1'b0);
    end

    task automatic push_frame(input logic [15:0] c0, input logic [15:0] c1);
        stream_q.push_back({c1, c0});
        exp_q.push_back({c1[11:0], c0[11:0]});
    endtask

    task automatic wait_frame_end(output bit ok);
        int f0 = frames;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_sclk);
            #2;
            if (frames != f0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_ncs_low(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_sclk);
            #2;
            if (bus.ncs === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.start = 0; bus.mic_en = 0; bus.cont = 0;
        bus.sample_ready = 0; bus.clr_overrun = 0;
        bus_s.start = 0; bus_s.mic_en = 0; bus_s.cont = 0;
        bus_s.sample_ready = 0; bus_s.clr_overrun = 0; bus_s.sdata = '0;
        stream_q.delete();
        exp_q.delete();
        exp_s_q.delete();
        bit_pos = -1;
        repeat (2) @(negedge clk_sclk);
        #2;
        rst = 1'b0;
        @(negedge clk_sclk);
        #2;
    endtask

    task automatic test_reset();
        bus.start = 0; bus.mic_en = 0; bus.cont = 0; bus.sdata = '0;
        bus.sample_ready = 0; bus.clr_overrun = 0;
        bus_s.start = 0; bus_s.mic_en = 0; bus_s.cont = 0; bus_s.sdata = '0;
        bus_s.sample_ready = 0; bus_s.clr_overrun = 0;
        #1 rst = 1'b1;
        #2;
        n_cmp++; if (bus.ncs !== 1'b1) begin n_err++; $display("FAIL reset_ncs got %b exp 1", bus.ncs); end
        n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL reset_done got %b exp 1", bus.done); end
        n_cmp++; if (bus.sample !== 24'h0) begin n_err++; $display("FAIL reset_sample got %h exp 0", bus.sample); end
        n_cmp++; if (bus.sample_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", bus.sample_valid); end
        n_cmp++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun got %b exp 0", bus.overrun); end
        repeat (2) @(negedge clk_sclk);
        #2 rst = 1'b0;
        bus.mic_en = 1'b1;
        repeat (6) @(negedge clk_sclk);
        #2;
        n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL idle_no_start_done got %b exp 1", bus.done); end
        n_cmp++; if (frames !== 0) begin n_err++; $display("FAIL idle_no_start_frames got %0d exp 0", frames); end
    endtask

    task automatic test_single_shot();
        bit ok;
        logic [23:0] exp;
        do_reset();
        push_frame(16'h0ABC, 16'h0123);
        bus.mic_en = 1; bus.cont = 0; bus.start = 1;
        wait_frame_end(ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL single_timeout got %b exp 1", ok); end
        exp = exp_q.pop_front();
        n_cmp++; if (bus.sample !== exp) begin n_err++; $display("FAIL single_sample got %h exp %h", bus.sample, exp); end
        n_cmp++; if (bus.sample_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b exp 1", bus.sample_valid); end
        n_cmp++; if (last_low !== 16) begin n_err++; $display("FAIL single_ncs_low got %0d exp 16", last_low); end
        repeat (3) @(negedge clk_sclk);
        #2;
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL single_hold_done got %b exp 0", bus.done); end
        n_cmp++; if (bus.ncs !== 1'b1) begin n_err++; $display("FAIL single_hold_ncs got %b exp 1", bus.ncs); end
        bus.start = 0;
        @(negedge clk_sclk);
        #2;
        n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL single_idle_done got %b exp 1", bus.done); end
        bus.sample_ready = 1;
        @(negedge clk_sclk);
        #2;
        bus.sample_ready = 0;
        n_cmp++; if (bus.sample_valid !== 1'b0) begin n_err++; $display("FAIL single_consume got %b exp 0", bus.sample_valid); end
    endtask

    task automatic test_continuous();
        bit ok;
        logic [23:0] exp;
        int f_base;
        do_reset();
        f_base = frames;
        push_frame(16'h0AAA, 16'h0111);
        push_frame(16'h0BBB, 16'hF222);
        push_frame(16'h5CCC, 16'h0333);
        bus.sample_ready = 1; bus.cont = 1; bus.mic_en = 1; bus.start = 1;
        for (int f = 0; f < 3; f++) begin
            wait_frame_end(ok);
            if (f == 2) bus.start = 0;
            n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL cont_timeout f%0d got %b exp 1", f, ok); end
            exp = exp_q.pop_front();
            n_cmp++; if (bus.sample !== exp) begin n_err++; $display("FAIL cont_sample f%0d got %h exp %h", f, bus.sample, exp); end
            n_cmp++; if (bus.sample_valid !== 1'b1) begin n_err++; $display("FAIL cont_valid f%0d got %b exp 1", f, bus.sample_valid); end
            n_cmp++; if (last_low !== 16) begin n_err++; $display("FAIL cont_ncs_low f%0d got %0d exp 16", f, last_low); end
            if (f > 0) begin
                n_cmp++; if (last_gap !== 2) begin n_err++; $display("FAIL cont_gap f%0d got %0d exp 2", f, last_gap); end
            end
        end
        repeat (4) @(negedge clk_sclk);
        #2;
        n_cmp++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL cont_overrun got %b exp 0", bus.overrun); end
        n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL cont_done got %b exp 1", bus.done); end
        n_cmp++; if (frames - f_base !== 3) begin n_err++; $display("FAIL cont_frames got %0d exp 3", frames - f_base); end
        bus.sample_ready = 0;
    endtask

    task automatic test_overrun();
        bit ok;
        logic [23:0] exp;
        do_reset();
        push_frame(16'h0321, 16'h0654);
        push_frame(16'h0987, 16'h0FED);
        push_frame(16'h0C0F, 16'h0E0D);
        bus.sample_ready = 0; bus.cont = 1; bus.mic_en = 1; bus.start = 1;
        wait_frame_end(ok);
        exp = exp_q.pop_front();
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL ovr_timeout1 got %b exp 1", ok); end
        n_cmp++; if (bus.sample !== exp) begin n_err++; $display("FAIL ovr_sample1 got %h exp %h", bus.sample, exp); end
        n_cmp++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL ovr_first got %b exp 0", bus.overrun); end
        wait_frame_end(ok);
        exp = exp_q.pop_front();
        n_cmp++; if (bus.sample !== exp) begin n_err++; $display("FAIL ovr_sample2 got %h exp %h", bus.sample, exp); end
        n_cmp++; if (bus.overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set got %b exp 1", bus.overrun); end
        bus.clr_overrun = 1;
        @(negedge clk_sclk);
        #2;
        n_cmp++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clear got %b exp 0", bus.overrun); end
        wait_frame_end(ok);
        bus.start = 0;
        exp = exp_q.pop_front();
        n_cmp++; if (bus.sample !== exp) begin n_err++; $display("FAIL ovr_sample3 got %h exp %h", bus.sample, exp); end
        n_cmp++; if (bus.overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set_wins got %b exp 1", bus.overrun); end
        @(negedge clk_sclk);
        #2;
        bus.clr_overrun = 0;
        n_cmp++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clear2 got %b exp 0", bus.overrun); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [23:0] exp;
        do_reset();
        push_frame(16'h0F0F, 16'h00F0);
        push_frame(16'h0A5A, 16'h05A5);
        bus.sample_ready = 0; bus.cont = 1; bus.mic_en = 1; bus.start = 1;
        wait_frame_end(ok);
        exp = exp_q.pop_front();
        n_cmp++; if (bus.sample !== exp) begin n_err++; $display("FAIL b2b_sample1 got %h exp %h", bus.sample, exp); end
        wait_ncs_low(ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL b2b_ncs_timeout got %b exp 1", ok); end
        repeat (15) @(negedge clk_sclk);
        #2;
        bus.sample_ready = 1;
        bus.start = 0;
        @(negedge clk_sclk);
        #2;
        exp = exp_q.pop_front();
        n_cmp++; if (bus.ncs !== 1'b1) begin n_err++; $display("FAIL b2b_frame_end got %b exp 1", bus.ncs); end
        n_cmp++; if (bus.sample !== exp) begin n_err++; $display("FAIL b2b_sample2 got %h exp %h", bus.sample, exp); end
        n_cmp++; if (bus.sample_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid got %b exp 1", bus.sample_valid); end
        n_cmp++; if (bus.overrun !== 1'b0) begin n_err++; $display("FAIL b2b_overrun got %b exp 0", bus.overrun); end
        @(negedge clk_sclk);
        #2;
        n_cmp++; if (bus.sample_valid !== 1'b0) begin n_err++; $display("FAIL b2b_consume got %b exp 0", bus.sample_valid); end
        bus.sample_ready = 0;
    endtask

    task automatic test_mic_drop();
        bit ok;
        logic [23:0] exp;
        int f_now;
        do_reset();
        push_frame(16'h1DEF, 16'h0456);
        bus.sample_ready = 0; bus.cont = 1; bus.mic_en = 1; bus.start = 1;
        wait_ncs_low(ok);
        repeat (8) @(negedge clk_sclk);
        #2;
        bus.mic_en = 0;
        wait_frame_end(ok);
        exp = exp_q.pop_front();
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL mic_timeout got %b exp 1", ok); end
        n_cmp++; if (bus.sample !== exp) begin n_err++; $display("FAIL mic_sample got %h exp %h", bus.sample, exp); end
        n_cmp++; if (bus.sample_valid !== 1'b1) begin n_err++; $display("FAIL mic_valid got %b exp 1", bus.sample_valid); end
        n_cmp++; if (last_low !== 16) begin n_err++; $display("FAIL mic_ncs_low got %0d exp 16", last_low); end
        f_now = frames;
        repeat (4) @(negedge clk_sclk);
        #2;
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL mic_hold got %b exp 0", bus.done); end
        bus.start = 0;
        @(negedge clk_sclk);
        #2;
        n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL mic_idle got %b exp 1", bus.done); end
        repeat (10) @(negedge clk_sclk);
        #2;
        n_cmp++; if (frames !== f_now) begin n_err++; $display("FAIL mic_no_new_frame got %0d exp %0d", frames, f_now); end
    endtask

    task automatic test_async_reset();
        bit ok;
        logic [23:0] exp;
        do_reset();
        push_frame(16'h0777, 16'h0888);
        push_frame(16'h0999, 16'h0AAA);
        bus.sample_ready = 0; bus.cont = 1; bus.mic_en = 1; bus.start = 1;
        wait_frame_end(ok);
        exp = exp_q.pop_front();
        n_cmp++; if (bus.sample !== exp) begin n_err++; $display("FAIL arst_sample got %h exp %h", bus.sample, exp); end
        wait_ncs_low(ok);
        repeat (5) @(negedge clk_sclk);
        @(posedge clk_sclk);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus.ncs !== 1'b1) begin n_err++; $display("FAIL arst_ncs got %b exp 1", bus.ncs); end
        n_cmp++; if (bus.sample_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid got %b exp 0", bus.sample_valid); end
        n_cmp++; if (bus.done !== 1'b1) begin n_err++; $display("FAIL arst_done got %b exp 1", bus.done); end
        n_cmp++; if (bus.sample !== 24'h0) begin n_err++; $display("FAIL arst_sample_clr got %h exp 0", bus.sample); end
        do_reset();
    endtask

    task automatic test_smoke();
        bit ok;
        logic [3:0] words [2];
        logic [3:0] w;
        logic [3:0] exp;
        words[0] = 4'hB;
        words[1] = 4'h6;
        do_reset();
        for (int n = 0; n < 2; n++) begin
            w = words[n];
            exp_s_q.push_back(w);
            bus_s.mic_en = 1; bus_s.cont = 0; bus_s.start = 1; bus_s.sample_ready = 0;
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk_sclk);
                #2;
                if (bus_s.ncs === 1'b0) begin
                    ok = 1'b1;
                    break;
                end
            end
            n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL smoke_start%0d got %b exp 1", n, ok); end
            for (int b = 3; b >= 0; b--) begin
                @(posedge clk_sclk);
                bus_s.sdata[0] = w[b];
                @(negedge clk_sclk);
                #2;
            end
            exp = exp_s_q.pop_front();
            n_cmp++; if (bus_s.ncs !== 1'b1) begin n_err++; $display("FAIL smoke_ncs%0d got %b exp 1", n, bus_s.ncs); end
            n_cmp++; if (bus_s.sample !== exp) begin n_err++; $display("FAIL smoke_sample%0d got %h exp %h", n, bus_s.sample, exp); end
            n_cmp++; if (bus_s.sample_valid !== 1'b1) begin n_err++; $display("FAIL smoke_valid%0d got %b exp 1", n, bus_s.sample_valid); end
            bus_s.start = 0;
            bus_s.sample_ready = 1;
            repeat (2) @(negedge clk_sclk);
            #2;
            bus_s.sample_ready = 0;
            n_cmp++; if (bus_s.done !== 1'b1) begin n_err++; $display("FAIL smoke_done%0d got %b exp 1", n, bus_s.done); end
        end
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_continuous();
        test_overrun();
        test_back_to_back();
        test_mic_drop();
        test_async_reset();
        test_smoke();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pmod_adc_capture.md
PMOD_ADC_CAPTURE -- requirements
Module: pmod_adc_capture

Interface
REQ-001 Parameter NUM_CH, default 1: number of ADC channels sharing one ncs and clk_sclk (legal 1..4).
REQ-002 Parameter FRAME_BITS, default 16: clk_sclk cycles per conversion with ncs low (legal 4..32).
REQ-003 Parameter DATA_BITS, default 12: result bits per channel, taken as the last DATA_BITS bits of the frame (legal 1..FRAME_BITS).
REQ-004 Parameter QUIET_CYCLES, default 1: minimum ncs-high cycles between frames (legal 1..15).
REQ-005 clk_sclk  in  1  the only clock; all sequential logic is updated on its falling edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  conversion request level.
REQ-008 mic_en  in  1  capture enable; gates the start of new frames only.
REQ-009 cont  in  1  1 = back-to-back frames while start && mic_en; 0 = single-shot.
REQ-010 sdata  in  NUM_CH  serial ADC data, one bit per channel, MSB first.
REQ-011 sample_ready  in  1  consumer accepts sample this edge.
REQ-012 clr_overrun  in  1  clears overrun.
REQ-013 ncs  out  1  ADC chip select, active low.
REQ-014 done  out  1  high exactly when state is IDLE.
REQ-015 sample  out  NUM_CH*DATA_BITS  channel k in bits [k*DATA_BITS +: DATA_BITS].
REQ-016 sample_valid  out  1  sample holds an unconsumed result.
REQ-017 overrun  out  1  sticky: a result was overwritten before being consumed.

Function
REQ-018 States IDLE, CONV, QUIET, HOLD; ncs = 0 only in CONV; ncs and done are decoded directly from state register (glitch-free, no extra latency).
REQ-019 IDLE -> CONV when start && mic_en; else remain.
REQ-020 CONV lasts exactly FRAME_BITS edges; bit counter loads FRAME_BITS-1 on CONV entry, decrements each edge, CONV -> QUIET when counter = 0.
REQ-021 In every CONV edge each channel shift register shifts left taking sdata[k] into bit 0.
REQ-022 On the CONV -> QUIET edge the low DATA_BITS of each shift register (including the final bit) load into sample and sample_valid sets; sample is stable otherwise.
REQ-023 QUIET lasts exactly QUIET_CYCLES edges; then: cont && start && mic_en -> CONV; else start -> HOLD; else IDLE.
REQ-024 HOLD -> IDLE when start = 0 (one conversion per start pulse in single-shot).
REQ-025 mic_en or start dropping during CONV does not abort: the frame completes and its result is delivered.
REQ-026 sample_valid clears on an edge with sample_ready = 1 and no new load; a load and a ready on the same edge leave sample_valid = 1 with new data and no overrun.
REQ-027 A load while sample_valid = 1 and sample_ready = 0 overwrites sample and sets overrun; overrun clears only on clr_overrun or rst; set wins over clear on the same edge.
REQ-028 Unreachable state encodings return to IDLE on the next edge.

Reset
REQ-029 rst asserted: state = IDLE, ncs = 1, done = 1, sample = 0, sample_valid = 0, overrun = 0, counters and shift registers = 0, immediately and asynchronously, including mid-frame.
REQ-030 First frame after rst release requires a fresh start && mic_en in IDLE.

Structure
REQ-031 Shared package pmod_adc_pkg holds the state encoding and the default parameter constants.
REQ-032 One sub-module, pmod_adc_shreg (FRAME_BITS-wide shift-in register with shift enable and parallel DATA_BITS output), instantiated NUM_CH times via generate.

Verification (NUM_CH=2, FRAME_BITS=16, DATA_BITS=12, QUIET_CYCLES=2 unless stated)
REQ-033 Single-shot: start=1, cont=0, ch0 stream 0x0ABC, ch1 0x0123 -> ncs low exactly 16 edges, sample = {12'h123,12'hABC}, sample_valid=1, then HOLD until start=0, done=1.
REQ-034 Continuous: start=cont=mic_en=1, sample_ready=1 for 3 frames -> ncs high exactly 2 edges between frames, three distinct results, overrun=0.
REQ-035 Overrun: continuous, sample_ready=0 -> second frame end sets overrun=1, sample = frame 2 data; clr_overrun pulse -> overrun=0.
REQ-036 Simultaneous ready/load on the frame-end edge -> sample_valid stays 1, overrun stays 0.
REQ-037 mic_en=0 at CONV bit 8 -> frame completes, result valid, state goes QUIET then HOLD/IDLE, no new frame.
REQ-038 rst pulse mid-CONV between edges -> ncs=1 and sample_valid=0 without a clock edge; NUM_CH=1, FRAME_BITS=4, DATA_BITS=4 smoke run also passes.
